// File: rtl/cv32e40p_tmr_fault_ctrl_if.sv
// Fault-manager handshake bundle: vote mismatch flags in,
// resync request, stall and fault status out.
interface cv32e40p_tmr_fault_ctrl_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 mismatch_valid_i;
  logic [2:0]           mismatch_i;
  logic                 resync_ack_i;
  logic                 resync_req_o;
  logic [1:0]           resync_id_o;
  logic                 stall_o;
  logic [2:0]           replica_disable_o;
  logic                 fatal_o;
  logic [CNT_WIDTH-1:0] fault_count_o;

  modport slave (
    input  mismatch_valid_i,
    input  mismatch_i,
    input  resync_ack_i,
    output resync_req_o,
    output resync_id_o,
    output stall_o,
    output replica_disable_o,
    output fatal_o,
    output fault_count_o
  );

  modport master (
    output mismatch_valid_i,
    output mismatch_i,
    output resync_ack_i,
    input  resync_req_o,
    input  resync_id_o,
    input  stall_o,
    input  replica_disable_o,
    input  fatal_o,
    input  fault_count_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// TMR fault manager: scores, resync sequencing, disable, fatal.
// Score decay is compiled in with CV32E40P_TMR_SCORE_DECAY_EN.
module cv32e40p_tmr_fault_ctrl #(
  parameter int CNT_WIDTH    = 8,
  parameter int THRESHOLD    = 4,
  parameter int DECAY_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  cv32e40p_tmr_fault_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    NORMAL,
    RESYNC,
    DEGRADED,
    FATAL
  } state_e;

  localparam logic [3:0] SCORE_MAX = 4'(THRESHOLD);

  state_e               state_q, state_d;
  logic [3:0]           score_q [3];
  logic [3:0]           score_d [3];
  logic [2:0]           dis_q, dis_d;
  logic [1:0]           id_q, id_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 req_q, stall_q, fatal_q;
  logic [2:0]           ev, ev_oth;
  logic                 multi;
  logic                 decay_tick;
  logic [1:0]           k_sel;

  assign ev = bus.mismatch_valid_i ?
              (bus.mismatch_i & ~dis_q) : 3'b000;
  assign multi = (ev[0] & ev[1]) |
                 (ev[0] & ev[2]) |
                 (ev[1] & ev[2]);
  assign ev_oth = ev & ~(3'b001 << id_q);

`ifdef CV32E40P_TMR_SCORE_DECAY_EN
  localparam int DW =
    (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  logic [DW-1:0] dcnt_q;

  assign decay_tick = (state_q == NORMAL) &&
                      (ev == 3'b000) &&
                      (dcnt_q == DW'(DECAY_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
    end else if (state_q != NORMAL || ev != 3'b000
                 || decay_tick) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_q + DW'(1);
    end
  end
`else
  assign decay_tick = 1'b0 & (DECAY_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    dis_d   = dis_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    k_sel   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (decay_tick && score_q[k] != 4'd0)
        score_d[k] = score_q[k] - 4'd1;
    end
    unique case (state_q)
      NORMAL: begin
        if (multi) begin
          state_d = FATAL;
        end else if (ev != 3'b000) begin
          unique case (1'b1)
            ev[0]:   k_sel = 2'd0;
            ev[1]:   k_sel = 2'd1;
            ev[2]:   k_sel = 2'd2;
            default: k_sel = 2'd0;
          endcase
          score_d[k_sel] = score_q[k_sel] + 4'd1;
          if (cnt_q != '1)
            cnt_d = cnt_q + CNT_WIDTH'(1);
          if (score_d[k_sel] == SCORE_MAX) begin
            dis_d[k_sel] = 1'b1;
            state_d      = DEGRADED;
          end else begin
            id_d    = k_sel;
            state_d = RESYNC;
          end
        end
      end
      // the replica being resynced is known bad; ignore it
      RESYNC: begin
        if (ev_oth != 3'b000)
          state_d = FATAL;
        else if (bus.resync_ack_i)
          state_d = NORMAL;
      end
      DEGRADED: begin
        if (ev != 3'b000)
          state_d = FATAL;
      end
      FATAL: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      score_q <= '{default: 4'd0};
      dis_q   <= 3'b000;
      id_q    <= 2'd0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      stall_q <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      dis_q   <= dis_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == RESYNC);
      stall_q <= (state_d == RESYNC) ||
                 (state_d == FATAL);
      fatal_q <= (state_d == FATAL);
    end
  end

  assign bus.resync_req_o      = req_q;
  assign bus.resync_id_o       = id_q;
  assign bus.stall_o           = stall_q;
  assign bus.replica_disable_o = dis_q;
  assign bus.fatal_o           = fatal_q;
  assign bus.fault_count_o     = cnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_ctrl.sv
// Scoreboard bench for cv32e40p_tmr_fault_ctrl against a
// behavioural fault-manager model.
module tb_cv32e40p_tmr_fault_ctrl;

  localparam int CW  = 3;
  localparam int THR = 4;
  localparam int DEC = 8;
  localparam int CMAX = (1 << CW) - 1;

  localparam int S_NORM  = 0;
  localparam int S_RES   = 1;
  localparam int S_DEG   = 2;
  localparam int S_FATAL = 3;

  typedef struct {
    logic          req;
    logic [1:0]    id;
    logic          stall;
    logic [2:0]    dis;
    logic          fatal;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q [$];
  bit   done = 1'b0;

  int       m_state;
  int       m_score [3];
  bit [2:0] m_dis;
  int       m_id;
  int       m_cnt;
  int       m_dc;

  cv32e40p_tmr_fault_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  cv32e40p_tmr_fault_ctrl #(
    .CNT_WIDTH(CW),
    .THRESHOLD(THR),
    .DECAY_CYCLES(DEC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_NORM;
    m_dis   = 3'b000;
    m_id    = 0;
    m_cnt   = 0;
    m_dc    = 0;
    for (int k = 0; k < 3; k++) m_score[k] = 0;
  endtask

  task automatic model_step(bit v, bit [2:0] mis, bit ack);
    bit [2:0] e;
    bit [2:0] oth;
    int n;
    int k;
    e = v ? (mis & ~m_dis) : 3'b000;
    n = $countones(e);
`ifdef CV32E40P_TMR_SCORE_DECAY_EN
    if (m_state == S_NORM && n == 0) begin
      if (m_dc == DEC - 1) begin
        m_dc = 0;
        for (int j = 0; j < 3; j++)
          if (m_score[j] > 0) m_score[j]--;
      end else begin
        m_dc++;
      end
    end else begin
      m_dc = 0;
    end
`endif
    case (m_state)
      S_NORM: begin
        if (n >= 2) begin
          m_state = S_FATAL;
        end else if (n == 1) begin
          k = e[0] ? 0 : (e[1] ? 1 : 2);
          m_score[k]++;
          if (m_cnt < CMAX) m_cnt++;
          if (m_score[k] == THR) begin
            m_dis[k] = 1'b1;
            m_state  = S_DEG;
          end else begin
            m_id    = k;
            m_state = S_RES;
          end
        end
      end
      S_RES: begin
        oth = e;
        oth[m_id] = 1'b0;
        if (oth != 3'b000) m_state = S_FATAL;
        else if (ack) m_state = S_NORM;
      end
      S_DEG: if (n > 0) m_state = S_FATAL;
      default: ;
    endcase
  endtask

  task automatic step(bit v, bit [2:0] mis, bit ack);
    exp_t x;
    @(negedge clk);
    bus.mismatch_valid_i = v;
    bus.mismatch_i       = mis;
    bus.resync_ack_i     = ack;
    model_step(v, mis, ack);
    x.req   = (m_state == S_RES);
    x.id    = 2'(m_id);
    x.stall = (m_state == S_RES) || (m_state == S_FATAL);
    x.dis   = m_dis;
    x.fatal = (m_state == S_FATAL);
    x.cnt   = CW'(m_cnt);
    sb_q.push_back(x);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.mismatch_valid_i = 1'b0;
    bus.mismatch_i       = 3'b000;
    bus.resync_ack_i     = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_req",   32'(bus.resync_req_o), 0);
    chk("rst_id",    32'(bus.resync_id_o), 0);
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_dis",   32'(bus.replica_disable_o), 0);
    chk("rst_fatal", 32'(bus.fatal_o), 0);
    chk("rst_cnt",   32'(bus.fault_count_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("req",   32'(bus.resync_req_o), 32'(x.req));
        chk("id",    32'(bus.resync_id_o), 32'(x.id));
        chk("stall", 32'(bus.stall_o), 32'(x.stall));
        chk("dis",   32'(bus.replica_disable_o),
            32'(x.dis));
        chk("fatal", 32'(bus.fatal_o), 32'(x.fatal));
        chk("cnt",   32'(bus.fault_count_o), 32'(x.cnt));
      end
    end
  end

  initial begin : stim
    bit [2:0] mis;
    bit v;
    bit a;
    bus.mismatch_valid_i = 1'b0;
    bus.mismatch_i       = 3'b000;
    bus.resync_ack_i     = 1'b0;
    model_reset();
    do_reset();

    // single fault, ack on the third request cycle
    step(1'b1, 3'b010, 1'b0);
    idle(1);
    step(1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b000, 1'b1);
    idle(2);

    // threshold on replica 0
    do_reset();
    for (int i = 0; i < THR; i++) begin
      step(1'b1, 3'b001, 1'b0);
      step(1'b0, 3'b000, 1'b1);
    end
    step(1'b1, 3'b001, 1'b0);
    idle(1);
    step(1'b1, 3'b100, 1'b0);
    idle(2);

    // double fault, sticky fatal
    do_reset();
    step(1'b1, 3'b011, 1'b0);
    idle(1);
    step(1'b1, 3'b010, 1'b1);
    idle(2);

    // fault on another replica during resync
    do_reset();
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    idle(2);

    // immediate ack, then a back-to-back new event
    do_reset();
    step(1'b1, 3'b100, 1'b0);
    step(1'b0, 3'b000, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    idle(1);

    // decay window followed by further faults
    do_reset();
    step(1'b1, 3'b010, 1'b0);
    step(1'b0, 3'b000, 1'b1);
    idle(DEC);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b010, 1'b0);
      step(1'b0, 3'b000, 1'b1);
    end
    idle(1);

    // fault counter saturation
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < THR - 1; i++) begin
        step(1'b1, 3'(1 << r), 1'b0);
        step(1'b0, 3'b000, 1'b1);
      end
    end
    idle(1);

    // reset while a resync is outstanding
    do_reset();
    step(1'b1, 3'b001, 1'b0);
    idle(1);
    do_reset();
    idle(1);

    // randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        v = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) < 8)
          mis = 3'(1 << $urandom_range(0, 2));
        else
          mis = 3'($urandom);
        a = ($urandom_range(0, 2) == 0);
        step(v, mis, a);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
